// File: rtl/oscillator_serdes_multi.sv
// Multi-channel fractional-period square-wave generator producing one serializer word per CLK
// per channel, with glitch-free period updates applied at rising output edges.
module oscillator_serdes_multi #(
  parameter int unsigned CHANNELS         = 2,
  parameter int unsigned SERDES_WIDTH     = 8,
  parameter int unsigned PERIOD_INT_PART  = 10,
  parameter int unsigned PERIOD_FRAC_PART = 20,
  parameter int unsigned MIN_HALF_INT     = 2
) (
  input  logic                                                   CLK,
  input  logic                                                   RESET_N,
  input  logic                                                   CE,
  input  logic [CHANNELS*(PERIOD_INT_PART+PERIOD_FRAC_PART)-1:0] PERIOD_IN,
  input  logic [CHANNELS-1:0]                                    PERIOD_WE,
  output logic [CHANNELS-1:0]                                    UPDATE_ACK,
  output logic [CHANNELS-1:0]                                    RUNNING,
  output logic [CHANNELS*SERDES_WIDTH-1:0]                       OUT_DATA
);

  localparam int unsigned PW    = PERIOD_INT_PART + PERIOD_FRAC_PART;
  localparam int unsigned EW    = PW + 1;
  localparam int unsigned EIW   = PERIOD_INT_PART + 1;
  localparam int unsigned ITERS = SERDES_WIDTH / MIN_HALF_INT + 1;

  localparam logic [EIW-1:0] WORD_INT = EIW'(SERDES_WIDTH);
  localparam logic [EW-1:0]  WORD_FX  = {WORD_INT, {PERIOD_FRAC_PART{1'b0}}};
  localparam logic [PW-1:0]  MIN_FX   = {PERIOD_INT_PART'(MIN_HALF_INT), {PERIOD_FRAC_PART{1'b0}}};

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Zero is the stop request and passes through untouched.
  function automatic logic [PW-1:0] clamp(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    r = v;
    if (v != '0 && v[PW-1:PERIOD_FRAC_PART] < PERIOD_INT_PART'(MIN_HALF_INT)) r = MIN_FX;
    return r;
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_e                  st_q, st_d;
    logic [PW-1:0]           h_q, h_d, p_q, p_d, val_q;
    logic                    pend_q, pend_d, l_q, l_d, ack_q, ack_d, we_q;
    logic [EW-1:0]           e_q, e_d;
    logic [SERDES_WIDTH-1:0] out_q, out_d;

    logic [EW-1:0]           e_w;
    logic [PW-1:0]           h_w;
    logic                    lvl, pend_w, stop_w, apply_w;
    logic [SERDES_WIDTH-1:0] word;

    // Unrolled edge walk across one word; each edge repaints all later bits.
    always_comb begin
      e_w     = e_q;
      h_w     = h_q;
      lvl     = l_q;
      pend_w  = pend_q;
      stop_w  = 1'b0;
      apply_w = 1'b0;
      word    = {SERDES_WIDTH{l_q}};
      for (int k = 0; k < ITERS; k++) begin
        if (!stop_w && e_w[EW-1:PERIOD_FRAC_PART] < WORD_INT) begin
          lvl = ~lvl;
          for (int i = 0; i < SERDES_WIDTH; i++) begin
            if (e_w[EW-1:PERIOD_FRAC_PART] <= EIW'(i)) word[i] = lvl;
          end
          if (pend_w && p_q == '0 && !lvl) stop_w = 1'b1;
          if (pend_w && p_q != '0 && lvl) begin
            h_w     = p_q;
            pend_w  = 1'b0;
            apply_w = 1'b1;
          end
          e_w = e_w + EW'(h_w);
        end
      end
    end

    always_comb begin
      st_d   = st_q;
      h_d    = h_q;
      p_d    = p_q;
      pend_d = pend_q;
      e_d    = e_q;
      l_d    = l_q;
      out_d  = '0;
      ack_d  = 1'b0;
      unique case (st_q)
        StIdle: begin
          if (we_q && val_q != '0) begin
            st_d  = StRun;
            h_d   = val_q;
            e_d   = '0;
            l_d   = 1'b0;
            ack_d = 1'b1;
          end
        end
        StRun: begin
          if (CE) begin
            out_d = word;
            ack_d = apply_w | stop_w;
            if (stop_w) begin
              st_d   = StIdle;
              h_d    = '0;
              p_d    = '0;
              pend_d = 1'b0;
              e_d    = '0;
              l_d    = 1'b0;
            end else begin
              h_d    = h_w;
              pend_d = pend_w;
              e_d    = e_w - WORD_FX;
              l_d    = word[SERDES_WIDTH-1];
            end
          end else begin
            out_d = {SERDES_WIDTH{l_q}};
          end
          // A write landing with an applying edge becomes the next pending value.
          if (we_q && !(CE && stop_w)) begin
            p_d    = val_q;
            pend_d = 1'b1;
          end
        end
        default: st_d = StIdle;
      endcase
    end

    always_ff @(posedge CLK) begin
      if (!RESET_N) begin
        st_q   <= StIdle;
        h_q    <= '0;
        p_q    <= '0;
        pend_q <= 1'b0;
        e_q    <= '0;
        l_q    <= 1'b0;
        out_q  <= '0;
        ack_q  <= 1'b0;
        we_q   <= 1'b0;
        val_q  <= '0;
      end else begin
        st_q   <= st_d;
        h_q    <= h_d;
        p_q    <= p_d;
        pend_q <= pend_d;
        e_q    <= e_d;
        l_q    <= l_d;
        out_q  <= out_d;
        ack_q  <= ack_d;
        we_q   <= PERIOD_WE[c];
        val_q  <= clamp(PERIOD_IN[c*PW +: PW]);
      end
    end

    assign OUT_DATA[c*SERDES_WIDTH +: SERDES_WIDTH] = out_q;
    assign UPDATE_ACK[c] = ack_q;
    assign RUNNING[c]    = (st_q == StRun);
  end

endmodule
